// File: rtl/reloj_soc_dbg_scan_bridge.sv
`default_nettype none
// ============================================================================
// Module   : reloj_soc_dbg_scan_bridge
// Brief    : Debug scan bridge. It captures and shifts per-channel words and
//            queues each update into a command FIFO for the CPU debug logic.
// Revision : 1.0
// ============================================================================
module reloj_soc_dbg_scan_bridge #(
    parameter int SR_W   = 38,
    parameter int IR_W   = 2,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     scan_tick,
    input  logic                     st_cdr,
    input  logic                     st_sdr,
    input  logic                     st_udr,
    input  logic                     st_uir,
    input  logic                     tdi,
    input  logic [IR_W-1:0]          ir_in,
    input  logic [NUM_CH*SR_W-1:0]   cap_data,
    output logic                     tdo,
    output logic [IR_W-1:0]          ir_out,
    output logic                     cmd_valid,
    output logic [IR_W-1:0]          cmd_ch,
    output logic [SR_W-1:0]          cmd_data,
    input  logic                     cmd_ready,
    input  logic                     clr_ovf,
    output logic                     ovf,
    output logic [7:0]               short_cnt
);

    localparam int BC_W  = $clog2(SR_W + 2);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [BC_W-1:0]  BC_FULL  = BC_W'(SR_W);
    localparam logic [BC_W-1:0]  BC_SAT   = BC_W'(SR_W + 1);
    localparam logic [IR_W:0]    CH_LIM   = (IR_W + 1)'(NUM_CH);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CAPTURED = 2'd1,
        S_SHIFTING = 2'd2,
        S_COMMIT   = 2'd3
    } state_t;

    state_t            state_q;
    logic [SR_W-1:0]   sr_q;
    logic [BC_W-1:0]   bc_q;
    logic              tdo_q;
    logic [IR_W-1:0]   ch_q;
    logic [7:0]        short_cnt_q;

    logic [IR_W-1:0]   mem_ch_q   [DEPTH];
    logic [SR_W-1:0]   mem_data_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    cnt_q;
    logic              ovf_q;

    logic [SR_W-1:0]   w_cap;
    logic              w_ch_ok;
    logic              w_active;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_accept;

    // Out-of-range channels capture zero rather than indexing past cap_data.
    always_comb begin
        w_cap = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ir_in == IR_W'(k)) begin
                w_cap = cap_data[k*SR_W +: SR_W];
            end
        end
    end

    assign w_ch_ok  = ({1'b0, ir_in} < CH_LIM);
    assign w_active = (state_q == S_CAPTURED) || (state_q == S_SHIFTING);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            sr_q        <= '0;
            bc_q        <= '0;
            tdo_q       <= 1'b0;
            ch_q        <= '0;
            short_cnt_q <= '0;
        end else if (state_q == S_COMMIT) begin
            state_q <= S_IDLE;
        end else if (scan_tick) begin
            if (st_cdr) begin
                sr_q    <= w_cap;
                bc_q    <= '0;
                state_q <= S_CAPTURED;
            end else if (st_sdr) begin
                if (w_active) begin
                    tdo_q   <= sr_q[0];
                    sr_q    <= {tdi, sr_q[SR_W-1:1]};
                    state_q <= S_SHIFTING;
                    if (bc_q != BC_SAT) begin
                        bc_q <= bc_q + 1'b1;
                    end
                end
            end else if (st_udr) begin
                if (w_active) begin
                    if ((bc_q == BC_FULL) && w_ch_ok) begin
                        ch_q    <= ir_in;
                        state_q <= S_COMMIT;
                    end else begin
                        state_q <= S_IDLE;
                        if (short_cnt_q != 8'hFF) begin
                            short_cnt_q <= short_cnt_q + 8'd1;
                        end
                    end
                end
            end else if (st_uir) begin
                bc_q    <= '0;
                state_q <= S_IDLE;
            end
        end
    end

    assign w_push   = (state_q == S_COMMIT);
    assign w_pop    = (cnt_q != '0) && cmd_ready;
    assign w_full   = (cnt_q == CNT_FULL);
    assign w_accept = w_push && (!w_full || w_pop);

    // A pop in the commit cycle frees the slot, so a full FIFO still accepts.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_ch_q[i]   <= '0;
                mem_data_q[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                mem_ch_q[wr_ptr_q]   <= ch_q;
                mem_data_q[wr_ptr_q] <= sr_q;
                wr_ptr_q             <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_accept, w_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (w_push && !w_accept) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign tdo       = tdo_q;
    assign short_cnt = short_cnt_q;
    assign ovf       = ovf_q;
    assign cmd_valid = (cnt_q != '0);
    assign cmd_ch    = mem_ch_q[rd_ptr_q];
    assign cmd_data  = mem_data_q[rd_ptr_q];

    always_comb begin
        ir_out    = '0;
        ir_out[0] = (cnt_q != '0);
        ir_out[1] = ovf_q;
    end

endmodule
`default_nettype wire
